// File: rtl/qbert_color_tracker.sv
// qbert_color_tracker: tracks which pyramid cubes Q*bert has recoloured.
// Each landing (rising edge of done_move) waits SETTLE cycles for the
// registered position detectors, samples the one-hot position and applies
// the colouring rule latched at level start.
//
// Interface timing: there is no valid/ready backpressure anywhere. done_move
// is a level whose rising edge (seen by this block at a clock edge) is the
// "valid" of one landing. position_qb must be stable by SETTLE cycles after
// that edge. e_level_start is a single-cycle command that is always accepted
// on the next edge unless e_pause_qb is high. Outputs are registered.
module qbert_color_tracker #(
    parameter int N_CUBE = 28,
    parameter int SETTLE = 2
) (
    input  logic              CLK_33,
    input  logic              reset,
    input  logic              done_move,
    input  logic [N_CUBE-1:0] position_qb,
    input  logic              e_level_start,
    input  logic [1:0]        e_mode,
    input  logic              e_pause_qb,
    output logic [N_CUBE-1:0] e_color_state,
    output logic [N_CUBE-1:0] e_hit_state,
    output logic [4:0]        cubes_done,
    output logic              color_event,
    output logic              level_done,
    output logic              illegal_pos,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ARMED       = 3'd1,
        SETTLE_WAIT = 3'd2,
        UPDATE      = 3'd3,
        COMPLETE    = 3'd4
    } state_t;

    localparam int CW = ($clog2(SETTLE + 1) < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);

    state_t            state, next_state;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [N_CUBE-1:0] cap, cap_nxt;
    logic [1:0]        mode, mode_nxt;
    logic              done_q;
    logic              rise;
    logic [N_CUBE-1:0] color_nxt, hit_nxt;
    logic              event_nxt, level_nxt, illegal_nxt, clear;
    logic [4:0]        pop;

    assign state_dbg = state;
    assign rise      = done_move & ~done_q;

    // Next-state and next-datapath logic; a level start overrides everything.
    always_comb begin
        next_state  = state;
        cnt_nxt     = cnt;
        cap_nxt     = cap;
        mode_nxt    = mode;
        color_nxt   = e_color_state;
        hit_nxt     = e_hit_state;
        event_nxt   = 1'b0;
        level_nxt   = level_done;
        illegal_nxt = illegal_pos;
        clear       = 1'b0;
        if (e_level_start) begin
            clear       = 1'b1;
            color_nxt   = '0;
            hit_nxt     = '0;
            level_nxt   = 1'b0;
            illegal_nxt = 1'b0;
            cnt_nxt     = '0;
            mode_nxt    = (e_mode == 2'd3) ? 2'd0 : e_mode;
            next_state  = ARMED;
        end else begin
            case (state)
                ARMED: begin
                    if (rise) begin
                        cnt_nxt    = SETTLE_LD;
                        next_state = SETTLE_WAIT;
                    end
                end
                SETTLE_WAIT: begin
                    if (cnt <= CW'(1)) begin
                        cnt_nxt    = '0;
                        cap_nxt    = position_qb;
                        next_state = UPDATE;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                UPDATE: begin
                    next_state = ARMED;
                    if (cap == '0) begin
                        // Off the pyramid (saucer or falling): nothing to record.
                    end else if ((cap & (cap - N_CUBE'(1))) != '0) begin
                        illegal_nxt = 1'b1;
                    end else begin
                        case (mode)
                            2'd1: color_nxt = e_color_state ^ cap;
                            2'd2: begin
                                if ((e_hit_state & cap) == '0) hit_nxt = e_hit_state | cap;
                                else color_nxt = e_color_state | cap;
                            end
                            default: color_nxt = e_color_state | cap;
                        endcase
                        event_nxt = (color_nxt != e_color_state) || (hit_nxt != e_hit_state);
                        if (&color_nxt) begin
                            level_nxt  = 1'b1;
                            next_state = COMPLETE;
                        end
                    end
                end
                default: ;  // IDLE and COMPLETE wait for a level start
            endcase
        end
    end

    // Population count of the current colour vector, registered below.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CUBE; i++) pop = pop + 5'(e_color_state[i]);
    end

    // State register; pause freezes it.
    always_ff @(posedge CLK_33 or posedge reset) begin
        if (reset) state <= IDLE;
        else if (!e_pause_qb) state <= next_state;
    end

    // Datapath registers; pause freezes everything and suppresses the event pulse.
    always_ff @(posedge CLK_33 or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            cap           <= '0;
            mode          <= 2'd0;
            done_q        <= 1'b0;
            e_color_state <= '0;
            e_hit_state   <= '0;
            cubes_done    <= '0;
            color_event   <= 1'b0;
            level_done    <= 1'b0;
            illegal_pos   <= 1'b0;
        end else if (e_pause_qb) begin
            color_event <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            cap           <= cap_nxt;
            mode          <= mode_nxt;
            done_q        <= done_move;
            e_color_state <= color_nxt;
            e_hit_state   <= hit_nxt;
            cubes_done    <= clear ? 5'd0 : pop;
            color_event   <= event_nxt;
            level_done    <= level_nxt;
            illegal_pos   <= illegal_nxt;
        end
    end

endmodule
